// File: rtl/core_dispatch_sched.sv
// core_dispatch_sched: hands out the tiles of a job to a pool of compute cores.
// For each tile it finds a free core round-robin, asks the act/weight loader to fill
// that core's row memories, fires a one-cycle core_start, and marks the core busy.
// Once every tile is issued it waits for all cores to finish, then pulses done.
// Optional feature: define DISPATCH_STALL_CNT_EN to build the 32-bit stall counter
// (SEARCH cycles with no free core); without it stall_cycles is tied to zero.
module core_dispatch_sched #(
  parameter int NUM_CORE = 4,
  parameter int TILE_W   = 16
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        start,
  input  logic [TILE_W-1:0]           num_tiles,
  output logic                        load_req,
  output logic [$clog2(NUM_CORE)-1:0] load_core_id,
  input  logic                        load_ack,
  output logic [NUM_CORE-1:0]         core_start,
  input  logic [NUM_CORE-1:0]         core_done,
  output logic [NUM_CORE-1:0]         busy_mask,
  output logic                        done,
  output logic [31:0]                 stall_cycles
);

  localparam int IdW = $clog2(NUM_CORE);

  typedef enum logic [2:0] {
    IDLE,
    SEARCH,
    LOAD,
    START,
    DRAIN,
    DONE
  } state_t;

  state_t              state_q, state_d;
  logic [NUM_CORE-1:0] busyMask_q, busyMask_d;
  logic [IdW-1:0]      rrPtr_q, rrPtr_d;
  logic [IdW-1:0]      grantId_q, grantId_d;
  logic [TILE_W-1:0]   tilesIssued_q, tilesIssued_d;
  logic [TILE_W-1:0]   numTiles_q, numTiles_d;

  logic [NUM_CORE-1:0] setMask;
  logic                freeFound;
  logic [IdW-1:0]      freeId;
  logic [IdW-1:0]      scanIdx;

  // Find the first idle core at or above the round-robin pointer, wrapping around.
  always_comb begin
    freeFound = 1'b0;
    freeId    = '0;
    scanIdx   = '0;
    for (int k = 0; k < NUM_CORE; k++) begin
      scanIdx = rrPtr_q + k[IdW-1:0];
      if (!freeFound && !busyMask_q[scanIdx]) begin
        freeFound = 1'b1;
        freeId    = scanIdx;
      end
    end
  end

  // Next-state logic for the job sequencer, including the one-hot start mask for START.
  always_comb begin
    state_d       = state_q;
    grantId_d     = grantId_q;
    rrPtr_d       = rrPtr_q;
    tilesIssued_d = tilesIssued_q;
    numTiles_d    = numTiles_q;
    setMask       = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          numTiles_d    = num_tiles;
          tilesIssued_d = '0;
          state_d       = (num_tiles == '0) ? DONE : SEARCH;
        end
      end
      SEARCH: begin
        if (freeFound) begin
          grantId_d = freeId;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        if (load_ack) begin
          state_d = START;
        end
      end
      START: begin
        setMask[grantId_q] = 1'b1;
        tilesIssued_d      = tilesIssued_q + 1'b1;
        rrPtr_d            = grantId_q + 1'b1;
        state_d            = (tilesIssued_d == numTiles_q) ? DRAIN : SEARCH;
      end
      DRAIN: begin
        if (busyMask_q == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Busy flags: completions clear, a fresh start sets, and the set wins on the same core.
  always_comb begin
    busyMask_d = (busyMask_q & ~core_done) | setMask;
  end

  // State and bookkeeping registers; reset aborts any job in flight.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= IDLE;
      busyMask_q    <= '0;
      rrPtr_q       <= '0;
      grantId_q     <= '0;
      tilesIssued_q <= '0;
      numTiles_q    <= '0;
    end else begin
      state_q       <= state_d;
      busyMask_q    <= busyMask_d;
      rrPtr_q       <= rrPtr_d;
      grantId_q     <= grantId_d;
      tilesIssued_q <= tilesIssued_d;
      numTiles_q    <= numTiles_d;
    end
  end

  // Handshake outputs decode the state and are held quiet while reset is asserted.
  always_comb begin
    load_req     = 1'b0;
    load_core_id = '0;
    core_start   = '0;
    done         = 1'b0;
    if (resetn) begin
      if (state_q == LOAD) begin
        load_req     = 1'b1;
        load_core_id = grantId_q;
      end
      core_start = setMask;
      done       = (state_q == DONE);
    end
  end

  assign busy_mask = busyMask_q;

`ifdef DISPATCH_STALL_CNT_EN
  logic [31:0] stallCnt_q, stallCnt_d;

  // Count SEARCH cycles that find every core busy, saturating; a new job clears it.
  always_comb begin
    stallCnt_d = stallCnt_q;
    if (state_q == IDLE && start) begin
      stallCnt_d = '0;
    end else if (state_q == SEARCH && !freeFound && stallCnt_q != '1) begin
      stallCnt_d = stallCnt_q + 32'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      stallCnt_q <= '0;
    end else begin
      stallCnt_q <= stallCnt_d;
    end
  end

  assign stall_cycles = stallCnt_q;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_core_dispatch_sched.sv
// tb_core_dispatch_sched: self-checking bench for core_dispatch_sched (NUM_CORE=4).
// The bench plays loader and cores. Its reference model keeps the set of busy cores,
// the round-robin pointer and per-core completion timers, and walks each tile as a
// transaction: wait for a free core, expect the fill request, acknowledge, expect the start.
module tb_core_dispatch_sched;

  localparam int NC  = 4;
  localparam int IdW = 2;
  localparam int TW  = 16;
`ifdef DISPATCH_STALL_CNT_EN
  localparam bit StallOn = 1'b1;
`else
  localparam bit StallOn = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           resetn;
  logic           start;
  logic [TW-1:0]  num_tiles;
  logic           load_req;
  logic [IdW-1:0] load_core_id;
  logic           load_ack;
  logic [NC-1:0]  core_start;
  logic [NC-1:0]  core_done;
  logic [NC-1:0]  busy_mask;
  logic           done;
  logic [31:0]    stall_cycles;

  core_dispatch_sched #(.NUM_CORE(NC), .TILE_W(TW)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .start        (start),
    .num_tiles    (num_tiles),
    .load_req     (load_req),
    .load_core_id (load_core_id),
    .load_ack     (load_ack),
    .core_start   (core_start),
    .core_done    (core_done),
    .busy_mask    (busy_mask),
    .done         (done),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [NC-1:0] mBusy;
  int            rr;
  int            doneTimer [NC];
  int            expStall;
  int            latMin;
  int            latMax;
  bit            noise;

  // observed pulse counters
  int startPulses = 0;
  int donePulses  = 0;

  always @(negedge clk) begin
    if (resetn) begin
      if (core_start != '0) startPulses++;
      if (done) donePulses++;
    end
  end

  // watchdog
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic model_clear();
    mBusy    = '0;
    rr       = 0;
    expStall = 0;
    for (int i = 0; i < NC; i++) doneTimer[i] = -1;
  endtask

  task automatic do_reset();
    resetn    = 1'b0;
    start     = 1'b0;
    load_ack  = 1'b0;
    core_done = '0;
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    model_clear();
  endtask

  // Advance one clock: emulate core completions, apply the model's busy update.
  task automatic step(input logic [NC-1:0] setMask, input logic [NC-1:0] forceDone);
    logic [NC-1:0] fin;
    fin = forceDone;
    for (int i = 0; i < NC; i++) begin
      if (mBusy[i] && forceDone[i]) begin
        doneTimer[i] = -1;
      end else if (mBusy[i] && doneTimer[i] == 0) begin
        fin[i]       = 1'b1;
        doneTimer[i] = -1;
      end else if (mBusy[i] && doneTimer[i] > 0) begin
        doneTimer[i]--;
      end
    end
    core_done = fin;
    @(posedge clk);
    mBusy = (mBusy & ~fin) | setMask;
    for (int i = 0; i < NC; i++) begin
      if (setMask[i]) doneTimer[i] = (latMax < 0) ? -1 : int'($urandom_range(latMax, latMin));
    end
    @(negedge clk);
    core_done = '0;
    load_ack  = 1'b0;
    start     = 1'b0;
  endtask

  // One tile: wait for a free core, expect its fill request, ack, expect its start.
  task automatic issue_tile(input int ackDelay, input logic [NC-1:0] forceAtStart);
    int            guard;
    int            g;
    logic [IdW-1:0] gid;
    logic [NC-1:0]  oh;
    guard = 0;
    while (&mBusy) begin
      checks++;
      if (load_req !== 1'b0 || core_start !== '0 || busy_mask !== mBusy) begin
        errors++;
        $display("[TB] FAIL search_stall: load_req=%b core_start=%b busy=%b, expected 0 0000 %b",
                 load_req, core_start, busy_mask, mBusy);
      end
      expStall++;
      if (noise) load_ack = 1'($urandom_range(0, 1));
      step('0, '0);
      guard++;
      if (guard > 400) begin
        checks++;
        errors++;
        $display("[TB] FAIL search_timeout: no core freed within 400 cycles");
        return;
      end
    end
    g = -1;
    for (int k = 0; k < NC; k++) begin
      if (g < 0 && !mBusy[(rr + k) % NC]) g = (rr + k) % NC;
    end
    gid = g[IdW-1:0];
    checks++;
    if (load_req !== 1'b0 || busy_mask !== mBusy) begin
      errors++;
      $display("[TB] FAIL search_pick: load_req=%b busy=%b, expected 0 %b", load_req, busy_mask, mBusy);
    end
    if (noise) load_ack = 1'($urandom_range(0, 1));
    step('0, '0);
    for (int d = 0; d <= ackDelay; d++) begin
      checks++;
      if (load_req !== 1'b1 || load_core_id !== gid || core_start !== '0 || busy_mask !== mBusy) begin
        errors++;
        $display("[TB] FAIL load_phase: load_req=%b id=%0d core_start=%b busy=%b, expected 1 %0d 0000 %b",
                 load_req, load_core_id, core_start, busy_mask, gid, mBusy);
      end
      if (d == ackDelay) begin
        load_ack = 1'b1;
      end else if (noise) begin
        start     = 1'($urandom_range(0, 1));
        num_tiles = TW'($urandom_range(0, 20));
      end
      step('0, '0);
    end
    oh    = '0;
    oh[g] = 1'b1;
    checks++;
    if (core_start !== oh || load_req !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL start_pulse: core_start=%b load_req=%b done=%b, expected %b 0 0",
               core_start, load_req, done, oh);
    end
    step(oh, forceAtStart);
    rr = (g + 1) % NC;
  endtask

  // Wait for every core to finish, then expect exactly one done pulse.
  task automatic finish_job();
    int guard;
    guard = 0;
    while (mBusy != '0) begin
      checks++;
      if (done !== 1'b0 || load_req !== 1'b0 || core_start !== '0 || busy_mask !== mBusy) begin
        errors++;
        $display("[TB] FAIL drain: done=%b load_req=%b core_start=%b busy=%b, expected 0 0 0000 %b",
                 done, load_req, core_start, busy_mask, mBusy);
      end
      if (noise) load_ack = 1'($urandom_range(0, 1));
      step('0, '0);
      guard++;
      if (guard > 400) begin
        checks++;
        errors++;
        $display("[TB] FAIL drain_timeout: cores still busy after 400 cycles");
        return;
      end
    end
    checks++;
    if (done !== 1'b0 || busy_mask !== '0) begin
      errors++;
      $display("[TB] FAIL drain_empty: done=%b busy=%b, expected 0 0000", done, busy_mask);
    end
    step('0, '0);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL done_pulse: done=%b, expected 1", done);
    end
    step('0, '0);
    checks++;
    if (done !== 1'b0 || load_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL done_single: done=%b load_req=%b, expected 0 0", done, load_req);
    end
  endtask

  task automatic run_job(input int numT, input int ackMin, input int ackMax);
    int expS;
    start     = 1'b1;
    num_tiles = TW'(numT);
    step('0, '0);
    expStall = 0;
    if (numT == 0) begin
      checks++;
      if (done !== 1'b1 || load_req !== 1'b0 || core_start !== '0) begin
        errors++;
        $display("[TB] FAIL zero_job: done=%b load_req=%b core_start=%b, expected 1 0 0000",
                 done, load_req, core_start);
      end
      step('0, '0);
      checks++;
      if (done !== 1'b0 || load_req !== 1'b0) begin
        errors++;
        $display("[TB] FAIL zero_job_end: done=%b load_req=%b, expected 0 0", done, load_req);
      end
    end else begin
      for (int t = 0; t < numT; t++) issue_tile(int'($urandom_range(ackMax, ackMin)), '0);
      finish_job();
    end
    expS = StallOn ? expStall : 0;
    checks++;
    if (stall_cycles !== 32'(expS)) begin
      errors++;
      $display("[TB] FAIL job_stall: stall_cycles=%0d, expected %0d", stall_cycles, expS);
    end
  endtask

  task automatic test_reset();
    resetn    = 1'b0;
    start     = 1'b1;
    num_tiles = 16'd5;
    load_ack  = 1'b1;
    core_done = '1;
    model_clear();
    latMin = 1; latMax = 1; noise = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (load_req !== 1'b0 || load_core_id !== '0 || core_start !== '0 || done !== 1'b0 ||
        busy_mask !== '0 || stall_cycles !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: load_req=%b id=%0d core_start=%b done=%b busy=%b stall=%0d, expected all 0",
               load_req, load_core_id, core_start, done, busy_mask, stall_cycles);
    end
    resetn    = 1'b1;
    start     = 1'b0;
    load_ack  = 1'b0;
    core_done = '0;
    step('0, '0);
    checks++;
    if (load_req !== 1'b0 || done !== 1'b0 || busy_mask !== '0) begin
      errors++;
      $display("[TB] FAIL reset_idle: load_req=%b done=%b busy=%b, expected 0 0 0000", load_req, done, busy_mask);
    end
  endtask

  task automatic test_zero_tiles();
    int s0;
    s0 = startPulses;
    run_job(0, 0, 0);
    checks++;
    if (startPulses !== s0) begin
      errors++;
      $display("[TB] FAIL zero_no_start: start pulses=%0d, expected %0d", startPulses, s0);
    end
  endtask

  task automatic test_three_no_done();
    do_reset();
    latMax = -1;
    start = 1'b1; num_tiles = 16'd3;
    step('0, '0);
    for (int t = 0; t < 3; t++) issue_tile(2, '0);
    checks++;
    if (busy_mask !== 4'b0111) begin
      errors++;
      $display("[TB] FAIL three_busy: busy=%b, expected 0111", busy_mask);
    end
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (done !== 1'b0 || load_req !== 1'b0 || core_start !== '0) begin
        errors++;
        $display("[TB] FAIL three_hold: done=%b load_req=%b core_start=%b, expected 0 0 0000",
                 done, load_req, core_start);
      end
      step('0, '0);
    end
  endtask

  task automatic test_six_tiles();
    int s0;
    int d0;
    do_reset();
    latMin = 10; latMax = 10;
    s0 = startPulses;
    d0 = donePulses;
    run_job(6, 0, 2);
    checks++;
    if (startPulses - s0 !== 6 || donePulses - d0 !== 1) begin
      errors++;
      $display("[TB] FAIL six_counts: starts=%0d dones=%0d, expected 6 1", startPulses - s0, donePulses - d0);
    end
  endtask

  task automatic test_stall();
    int expS;
    do_reset();
    latMax = -1;
    start = 1'b1; num_tiles = 16'd5;
    step('0, '0);
    expStall = 0;
    for (int t = 0; t < 4; t++) issue_tile(1, '0);
    doneTimer[2] = 6;
    issue_tile(1, '0);
    expS = StallOn ? 7 : 0;
    checks++;
    if (stall_cycles !== 32'(expS) || busy_mask !== 4'b1111) begin
      errors++;
      $display("[TB] FAIL stall_grant: stall_cycles=%0d busy=%b, expected %0d 1111", stall_cycles, busy_mask, expS);
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    latMax = -1;
    start = 1'b1; num_tiles = 16'd4;
    step('0, '0);
    for (int t = 0; t < 3; t++) issue_tile(0, '0);
    issue_tile(0, 4'b0010);
    checks++;
    if (busy_mask !== 4'b1101) begin
      errors++;
      $display("[TB] FAIL set_clear_same_edge: busy=%b, expected 1101", busy_mask);
    end
  endtask

  task automatic test_reset_mid_load();
    do_reset();
    latMax = -1;
    start = 1'b1; num_tiles = 16'd3;
    step('0, '0);
    issue_tile(1, '0);
    step('0, '0);
    checks++;
    if (load_req !== 1'b1 || load_core_id !== 2'd1) begin
      errors++;
      $display("[TB] FAIL mid_load_setup: load_req=%b id=%0d, expected 1 1", load_req, load_core_id);
    end
    resetn    = 1'b0;
    core_done = 4'b0001;
    start     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (load_req !== 1'b0 || busy_mask !== '0 || core_start !== '0 || done !== 1'b0 || load_core_id !== '0) begin
      errors++;
      $display("[TB] FAIL mid_load_reset: load_req=%b busy=%b core_start=%b done=%b id=%0d, expected 0 0000 0000 0 0",
               load_req, busy_mask, core_start, done, load_core_id);
    end
    resetn    = 1'b1;
    core_done = '0;
    start     = 1'b0;
    model_clear();
    latMin = 2; latMax = 6;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (done !== 1'b0 || load_req !== 1'b0) begin
        errors++;
        $display("[TB] FAIL after_abort: done=%b load_req=%b, expected 0 0", done, load_req);
      end
      step('0, '0);
    end
    run_job(2, 1, 1);
  endtask

  task automatic test_random();
    do_reset();
    noise = 1'b1;
    for (int j = 0; j < 10; j++) begin
      latMin = 1;
      latMax = int'($urandom_range(1, 20));
      run_job(int'($urandom_range(0, 12)), 0, 3);
    end
    noise = 1'b0;
  endtask

  initial begin
    test_reset();
    test_zero_tiles();
    test_three_no_done();
    test_six_tiles();
    test_stall();
    test_same_cycle();
    test_reset_mid_load();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
